// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified instruction/data RAM.
// Latency: combinational helpers only.
// Backpressure: none; used by the port pipelines and lane logic.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] data;
    } mem_rsp_t;

    // Misaligned, illegal-size or out-of-range access. The range test uses the full
    // word address so an address past the end never wraps onto low memory.
    function automatic logic mem_fault(input logic [31:0] addr,
                                       input logic [1:0]  size,
                                       input logic [31:0] words);
        logic misaligned;
        logic bad_size;
        misaligned = 1'b0;
        bad_size   = 1'b0;
        case (size)
            MEM_BYTE: misaligned = 1'b0;
            MEM_HALF: misaligned = addr[0];
            MEM_WORD: misaligned = |addr[1:0];
            default:  bad_size   = 1'b1;
        endcase
        return misaligned || bad_size || ({2'b00, addr[31:2]} >= words);
    endfunction

    // Byte lanes written by a store of the given size at the given lane offset.
    function automatic logic [3:0] mem_byte_en(input logic [1:0] lane,
                                               input logic [1:0] size);
        case (size)
            MEM_BYTE: return 4'b0001 << lane;
            MEM_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            MEM_WORD: return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

    // Store data replicated across lanes so every enabled lane sees the LSB-aligned value.
    function automatic logic [31:0] mem_store_lanes(input logic [31:0] wdata,
                                                    input logic [1:0]  size);
        case (size)
            MEM_BYTE: return {4{wdata[7:0]}};
            MEM_HALF: return {2{wdata[15:0]}};
            default:  return wdata;
        endcase
    endfunction

    // Pick the addressed lane out of a RAM word and sign- or zero-extend it.
    function automatic logic [31:0] mem_load_ext(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            MEM_BYTE: return {{24{~uns & shifted[7]}},  shifted[7:0]};
            MEM_HALF: return {{16{~uns & shifted[15]}}, shifted[15:0]};
            default:  return word;
        endcase
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Stall-able response shift pipeline, one per memory port.
// Latency: payload presented at stage 0 appears at the output LATENCY-1 edges after it is loaded.
// Backpressure: the whole pipeline freezes while the output is valid and not consumed; o_ready drops.
module mem_resp_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  mem_rsp_t i_rsp,        // i_rsp.valid is the port request; taken only when o_ready
    input  logic     i_rsp_ready,
    output logic     o_ready,
    output mem_rsp_t o_rsp
);

    mem_rsp_t r_stage [LATENCY];
    logic     w_stall;

    assign w_stall = r_stage[LATENCY-1].valid && !i_rsp_ready;
    assign o_ready = !reset && !w_stall;
    assign o_rsp   = r_stage[LATENCY-1];

    // Shift responses toward the output; bubbles carry zero data so idle outputs read 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else if (!w_stall) begin
            r_stage[0] <= i_rsp.valid ? i_rsp : '0;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

endmodule

// File: rtl/pipelined_memory.sv
// Unified instruction/data RAM: read-only word fetch port plus byte/half/word load/store port.
// Latency: accept at edge N, response valid from edge N+READ_LATENCY-1; RAM read-first at the accept edge.
// Backpressure: per-port; an unconsumed valid response freezes that port's pipeline and drops its ready.
module pipelined_memory
    import mem_pkg::*;
#(
    parameter int MEMORY_WORDS = 65536,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic        i_req,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic        i_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] i_rdata,
    output logic        i_fault,
    // load/store port
    input  logic        d_req,
    output logic        d_ready,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rdata,
    output logic        d_fault
);

    localparam int          AW    = (MEMORY_WORDS > 1) ? $clog2(MEMORY_WORDS) : 1;
    localparam logic [31:0] WORDS = 32'(MEMORY_WORDS);

    // Not reset: contents survive reset and are loaded from the simulation image.
    logic [31:0] r_mem [MEMORY_WORDS];

    // fetch side
    logic [AW-1:0] w_i_idx;
    logic          w_i_fault;
    logic [31:0]   w_i_word;
    mem_rsp_t      w_i_rsp_in;
    mem_rsp_t      w_i_rsp_out;

    // data side
    logic [AW-1:0] w_d_idx;
    logic          w_d_fault;
    logic [31:0]   w_d_word;
    logic [31:0]   w_d_load;
    logic          w_d_wr;
    logic [3:0]    w_d_be;
    logic [31:0]   w_d_wlanes;
    mem_rsp_t      w_d_rsp_in;
    mem_rsp_t      w_d_rsp_out;

    // Fetch: always a word load. Faulted fetches never look at the RAM word.
    assign w_i_idx   = i_addr[AW+1:2];
    assign w_i_fault = mem_fault(i_addr, MEM_WORD, WORDS);
    assign w_i_word  = r_mem[w_i_idx];

    // Build the fetch response entering stage 0 of its pipeline.
    always_comb begin
        w_i_rsp_in       = '0;
        w_i_rsp_in.valid = i_req;
        w_i_rsp_in.fault = w_i_fault;
        w_i_rsp_in.data  = w_i_fault ? 32'h0 : w_i_word;
    end

    // Load/store: lane extraction happens before the pipeline so a stall never re-reads RAM.
    assign w_d_idx    = d_addr[AW+1:2];
    assign w_d_fault  = mem_fault(d_addr, d_size, WORDS);
    assign w_d_word   = r_mem[w_d_idx];
    assign w_d_load   = mem_load_ext(w_d_word, d_addr[1:0], d_size, d_unsigned);
    assign w_d_be     = mem_byte_en(d_addr[1:0], d_size);
    assign w_d_wlanes = mem_store_lanes(d_wdata, d_size);
    // d_ready is already low during reset and stalls, so no write slips through either.
    assign w_d_wr     = d_req && d_ready && d_we && !w_d_fault;

    // Build the data response; stores and faults always return zero data.
    always_comb begin
        w_d_rsp_in       = '0;
        w_d_rsp_in.valid = d_req;
        w_d_rsp_in.fault = w_d_fault;
        w_d_rsp_in.data  = (w_d_fault || d_we) ? 32'h0 : w_d_load;
    end

    // Commit stores on the accept edge, touching only the enabled byte lanes.
    always_ff @(posedge clk) begin
        if (w_d_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_d_be[b]) begin
                    r_mem[w_d_idx][8*b +: 8] <= w_d_wlanes[8*b +: 8];
                end
            end
        end
    end

    mem_resp_pipe #(
        .LATENCY(READ_LATENCY)
    ) u_i_pipe (
        .clk        (clk),
        .reset      (reset),
        .i_rsp      (w_i_rsp_in),
        .i_rsp_ready(i_rsp_ready),
        .o_ready    (i_ready),
        .o_rsp      (w_i_rsp_out)
    );

    mem_resp_pipe #(
        .LATENCY(READ_LATENCY)
    ) u_d_pipe (
        .clk        (clk),
        .reset      (reset),
        .i_rsp      (w_d_rsp_in),
        .i_rsp_ready(d_rsp_ready),
        .o_ready    (d_ready),
        .o_rsp      (w_d_rsp_out)
    );

    assign i_rsp_valid = w_i_rsp_out.valid;
    assign i_fault     = w_i_rsp_out.fault;
    assign i_rdata     = w_i_rsp_out.data;

    assign d_rsp_valid = w_d_rsp_out.valid;
    assign d_fault     = w_d_rsp_out.fault;
    assign d_rdata     = w_d_rsp_out.data;

endmodule

// File: tb/tb_pipelined_memory.sv
module tb_pipelined_memory;
    import mem_pkg::*;

    localparam int MW  = 1024;
    localparam int LAT = 3;

    logic        clk;
    logic        reset;
    logic        i_req, i_ready, i_rsp_valid, i_rsp_ready, i_fault;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_ready, d_we, d_unsigned, d_rsp_valid, d_rsp_ready, d_fault;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    pipelined_memory #(
        .MEMORY_WORDS(MW),
        .READ_LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_ready    (i_ready),
        .i_addr     (i_addr),
        .i_rsp_valid(i_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .i_rdata    (i_rdata),
        .i_fault    (i_fault),
        .d_req      (d_req),
        .d_ready    (d_ready),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rsp_valid(d_rsp_valid),
        .d_rsp_ready(d_rsp_ready),
        .d_rdata    (d_rdata),
        .d_fault    (d_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single data-port transaction; call just after a rising edge. lat counts negedges
    // after the accept edge until the response shows (3 for LAT=3), -1 on timeout.
    task automatic d_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic flt, output int lat);
        logic acc;
        rd  = 32'h0;
        flt = 1'b0;
        lat = -1;
        acc = 1'b0;
        d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = d_ready;
            @(posedge clk); #1;
        end
        d_req = 1'b0;
        if (!acc) return;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (d_rsp_valid) begin
                rd = d_rdata; flt = d_fault; lat = c;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic i_fetch(input logic [31:0] a, output logic [31:0] rd,
                           output logic flt, output int lat);
        logic acc;
        rd  = 32'h0;
        flt = 1'b0;
        lat = -1;
        acc = 1'b0;
        i_req = 1'b1; i_addr = a;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = i_ready;
            @(posedge clk); #1;
        end
        i_req = 1'b0;
        if (!acc) return;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (i_rsp_valid) begin
                rd = i_rdata; flt = i_fault; lat = c;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int lat;
        i_req = 1'b1; i_addr = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready got i=%0b d=%0b want 0 0", i_ready, d_ready);
        end
        tests_run++;
        if (i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rsp_valid got i=%0b d=%0b want 0 0", i_rsp_valid, d_rsp_valid);
        end
        tests_run++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || i_fault !== 1'b0 || d_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got i_rdata=%h d_rdata=%h i_fault=%0b d_fault=%0b want all 0",
                     i_rdata, d_rdata, i_fault, d_fault);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (i_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_i_ready got %0b want 1", i_ready);
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (i_rsp_valid) begin lat = c; break; end
        end
        tests_run++;
        if (lat != LAT || i_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_fetch got lat=%0d fault=%0b want lat=%0d fault=0", lat, i_fault, LAT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        flt;
        int          lat;
        int          n;
        d_access(1'b1, MEM_WORD, 1'b0, 32'h100, 32'hDEADBEEF, rd, flt, lat);
        tests_run++;
        if (lat != LAT || flt !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL store_word got lat=%0d fault=%0b rdata=%h want lat=%0d fault=0 rdata=0",
                     lat, flt, rd, LAT);
        end
        n = 0;
        d_req = 1'b1; d_we = 1'b0; d_size = MEM_WORD; d_unsigned = 1'b0; d_addr = 32'h100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 4) begin
                tests_run++;
                if (d_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_ready cycle %0d got %0b want 1", c, d_ready);
                end
            end
            if (d_rsp_valid) begin
                tests_run++;
                if (c != n + LAT || d_rdata !== 32'hDEADBEEF) begin
                    tests_failed++;
                    $display("FAIL b2b_rsp %0d got cycle=%0d data=%h want cycle=%0d data=deadbeef",
                             n, c, d_rdata, n + LAT);
                end
                n++;
            end
            @(posedge clk); #1;
            if (c == 3) d_req = 1'b0;
        end
        tests_run++;
        if (n != 4) begin
            tests_failed++;
            $display("FAIL b2b_count got %0d want 4", n);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic        flt;
        int          lat;
        d_access(1'b1, MEM_WORD, 1'b0, 32'h100, 32'h11223344, rd, flt, lat);
        d_access(1'b1, MEM_BYTE, 1'b0, 32'h101, 32'h00000080, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b0 || lat != LAT) begin
            tests_failed++;
            $display("FAIL store_byte got fault=%0b lat=%0d want 0 %0d", flt, lat, LAT);
        end
        d_access(1'b0, MEM_BYTE, 1'b0, 32'h101, 32'h0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'hFFFFFF80 || flt !== 1'b0) begin
            tests_failed++;
            $display("FAIL ldb_signed got %h fault=%0b want ffffff80", rd, flt);
        end
        d_access(1'b0, MEM_BYTE, 1'b1, 32'h101, 32'h0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'h00000080) begin
            tests_failed++;
            $display("FAIL ldb_unsigned got %h want 00000080", rd);
        end
        d_access(1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'h11228044) begin
            tests_failed++;
            $display("FAIL ldw_after_byte got %h want 11228044", rd);
        end
        d_access(1'b0, MEM_HALF, 1'b0, 32'h100, 32'h0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'hFFFF8044) begin
            tests_failed++;
            $display("FAIL ldh_signed got %h want ffff8044", rd);
        end
        d_access(1'b0, MEM_HALF, 1'b1, 32'h102, 32'h0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'h00001122) begin
            tests_failed++;
            $display("FAIL ldh_unsigned got %h want 00001122", rd);
        end
        d_access(1'b0, MEM_BYTE, 1'b0, 32'h103, 32'h0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'h00000011) begin
            tests_failed++;
            $display("FAIL ldb_lane3 got %h want 00000011", rd);
        end
        d_access(1'b1, MEM_HALF, 1'b0, 32'h102, 32'hFFFFA5A5, rd, flt, lat);
        d_access(1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'hA5A58044) begin
            tests_failed++;
            $display("FAIL ldw_after_half got %h want a5a58044", rd);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic        flt;
        int          lat;
        d_access(1'b1, MEM_WORD, 1'b0, 32'h0, 32'h0BADC0DE, rd, flt, lat);
        d_access(1'b0, MEM_HALF, 1'b0, 32'h103, 32'h0, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1 || rd !== 32'h0 || lat != LAT) begin
            tests_failed++;
            $display("FAIL half_misaligned got fault=%0b rdata=%h lat=%0d want 1 0 %0d", flt, rd, lat, LAT);
        end
        d_access(1'b1, MEM_WORD, 1'b0, 32'h102, 32'hCAFEF00D, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL word_misaligned_store got fault=%0b rdata=%h want 1 0", flt, rd);
        end
        d_access(1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'hA5A58044 || flt !== 1'b0) begin
            tests_failed++;
            $display("FAIL ram_unchanged_misaligned got %h fault=%0b want a5a58044 0", rd, flt);
        end
        d_access(1'b1, MEM_WORD, 1'b0, 32'(4 * MW), 32'hFFFFFFFF, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL store_out_of_range got fault=%0b rdata=%h want 1 0", flt, rd);
        end
        d_access(1'b0, MEM_WORD, 1'b0, 32'h0, 32'h0, rd, flt, lat);
        tests_run++;
        if (rd !== 32'h0BADC0DE || flt !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_wrap_write got %h fault=%0b want 0badc0de 0", rd, flt);
        end
        d_access(1'b0, MEM_BYTE, 1'b0, 32'(4 * MW), 32'h0, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL load_out_of_range got fault=%0b rdata=%h want 1 0", flt, rd);
        end
        d_access(1'b0, MEM_WORD, 1'b0, 32'(4 * MW - 4), 32'h0, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b0) begin
            tests_failed++;
            $display("FAIL last_word_in_range got fault=%0b want 0", flt);
        end
        d_access(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL illegal_size got fault=%0b rdata=%h want 1 0", flt, rd);
        end
        i_fetch(32'(4 * MW), rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1 || rd !== 32'h0 || lat != LAT) begin
            tests_failed++;
            $display("FAIL fetch_out_of_range got fault=%0b rdata=%h lat=%0d want 1 0 %0d", flt, rd, lat, LAT);
        end
        i_fetch(32'h102, rd, flt, lat);
        tests_run++;
        if (flt !== 1'b1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL fetch_misaligned got fault=%0b rdata=%h want 1 0", flt, rd);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        logic        flt;
        int          lat;
        int          k;
        int          n;
        logic        acc;
        logic        saw_stall;
        logic        have_prev;
        logic [31:0] prev_data;
        for (int j = 0; j < 4; j++) begin
            d_access(1'b1, MEM_WORD, 1'b0, 32'h300 + 32'(4 * j), 32'hA0000000 + 32'(j), rd, flt, lat);
        end
        k = 0; n = 0; saw_stall = 1'b0; have_prev = 1'b0; prev_data = 32'h0;
        d_rsp_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_size = MEM_WORD; d_unsigned = 1'b0; d_addr = 32'h300;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            acc = d_req && d_ready;
            if (d_req && !d_ready) saw_stall = 1'b1;
            if (have_prev && d_rsp_valid) begin
                tests_run++;
                if (d_rdata !== prev_data) begin
                    tests_failed++;
                    $display("FAIL stall_stable cycle %0d got %h want %h", c, d_rdata, prev_data);
                end
            end
            if (d_rsp_valid && d_rsp_ready) begin
                tests_run++;
                if (d_rdata !== 32'hA0000000 + 32'(n) || d_fault !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall_order rsp %0d got %h fault=%0b want %h",
                             n, d_rdata, d_fault, 32'hA0000000 + 32'(n));
                end
                n++;
            end
            have_prev = d_rsp_valid && !d_rsp_ready;
            prev_data = d_rdata;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                d_addr = 32'h300 + 32'(4 * k);
                if (k == 4) d_req = 1'b0;
            end
            if (c >= 4) d_rsp_ready = 1'b1;
        end
        d_req = 1'b0;
        tests_run++;
        if (saw_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_ready_drop got saw_stall=%0b want 1", saw_stall);
        end
        tests_run++;
        if (n != 4 || k != 4) begin
            tests_failed++;
            $display("FAIL stall_count got rsp=%0d accepted=%0d want 4 4", n, k);
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] rd;
        logic        flt;
        int          lat;
        logic [31:0] got [2];
        int          n;
        d_access(1'b1, MEM_WORD, 1'b0, 32'h200, 32'h00000001, rd, flt, lat);
        got[0] = 32'h0; got[1] = 32'h0; n = 0;
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_size = MEM_WORD; d_addr = 32'h200; d_wdata = 32'h00000002;
        @(negedge clk);
        tests_run++;
        if (i_ready !== 1'b1 || d_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_edge_ready got i=%0b d=%0b want 1 1", i_ready, d_ready);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (i_rsp_valid && n < 2) begin
                got[n] = i_rdata;
                n++;
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (n != 2 || got[0] !== 32'h1 || got[1] !== 32'h2) begin
            tests_failed++;
            $display("FAIL read_first got n=%0d first=%h second=%h want 2 1 2", n, got[0], got[1]);
        end
    endtask

    initial begin
        reset = 1'b0;
        i_req = 1'b0; i_addr = 32'h0; i_rsp_ready = 1'b1;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_unsigned = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_rsp_ready = 1'b1;
        #2;
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_faults();
        test_stall();
        test_same_edge();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
